connect_four_matrix_driver: RTL and testbench
=============================================

# connect_four_matrix_driver

Display back-end for the Connect Four core. It scans the 8×8 board through the core's read port (`row_read`/`col_read` → registered `data_out`) and builds one serial word per board row. It shifts each word into an external chain of three 8-bit shift registers (row-select, red, green) driving a bicolour LED matrix. It also overlays the drop cursor and blanks the display on game over.

## Interface
Parameters:
- `CLK_DIV`, 4: shift-clock half-period in `clk` cycles; legal range 1..255.
- `BLINK_BITS`, 22: width of the free-running blink counter; its MSB is the blink phase.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `row_read`  out  3  board row address to the core
- `col_read`  out  3  board column address to the core
- `data_in`  in  2  cell contents from the core's `data_out`, valid 1 cycle after the address; 00 empty, 01 P1, 10 P2, 11 treated as empty
- `cur_col`  in  3  cursor column (core `port_current_col`)
- `cur_player`  in  2  player to move (core `port_current_player`)
- `game_over`  in  1  core win flag
- `sr_data`  out  1  serial data, MSB first
- `sr_clk`  out  1  shift clock; external registers sample on the rising edge
- `sr_latch`  out  1  storage-register latch pulse
- `frame_done`  out  1  one-cycle pulse after row 7 is latched

## Operation
- FSM states: FETCH → SHIFT → LATCH → FETCH (next row). Row index runs 0..7 and wraps to 0.
- FETCH, 9 cycles:
  - `row_read` = current row; `col_read` steps 0..7 on cycles 0..7.
  - Cell c is captured from `data_in` on cycle c+1.
  - `col_read` holds 7 on cycle 8, then resets to 0 at the next FETCH.
- Word, 24 bits, sent MSB first: {sel[7:0], red[7:0], green[7:0]}.
  - sel = one-hot, bit r set for row r.
  - red[c] = cell==01; green[c] = cell==10.
- Cursor overlay, row 7 only:
  - Applies when blink phase = 1, game_over = 0, and cell (7, cur_col) is empty.
  - bit cur_col of red is set if cur_player==01; of green if cur_player==10.
  - Occupied cells are never overridden.
- Game over: when game_over=1 and blink phase=0, red and green are forced to 0. sel is unchanged.
- Blink phase: MSB of the `BLINK_BITS` counter, which increments every cycle. The phase is sampled once, on the first FETCH cycle of row 0, and held for the whole frame. cur_col, cur_player and game_over are sampled at the same point.
- Fetch coherency: the core only honours `row_read`/`col_read` in its idle state. Stale data captured during a drop or victory check is accepted as-is and corrected on the next frame. No handshake.

## Timing
- Reset values: `sr_data`=0, `sr_clk`=0, `sr_latch`=0, `row_read`=0, `col_read`=0, `frame_done`=0, blink counter=0.
  - Reset state is FETCH, row 0, cycle 0.
  - Reset asserted mid-frame aborts immediately. No partial latch pulse is emitted.
- SHIFT:
  - Each bit lasts 2·CLK_DIV cycles.
  - `sr_data` is updated with `sr_clk` low and held for CLK_DIV cycles.
  - `sr_clk` is then high for CLK_DIV cycles.
  - 24 bits take 48·CLK_DIV cycles; SHIFT ends with `sr_clk` low.
- LATCH: `sr_latch`=1 for CLK_DIV cycles; `sr_clk`=0 and `sr_data`=0 throughout.
- Row period = 9 + 49·CLK_DIV cycles (58 at CLK_DIV=1; 205 at CLK_DIV=4).
- `frame_done` is high on the first cycle after row 7's LATCH ends, coincident with FETCH cycle 0 of row 0. Period = 8 row periods.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `rst` for 2 cycles.
  - During reset, all outputs = 0.
  - After release, `col_read` = 0,1,…,7 on consecutive cycles with `row_read`=0.
  - First `sr_clk` rise occurs CLK_DIV cycles after SHIFT entry.
- Empty board, CLK_DIV=1, game_over=0, cursor phase 0:
  - Row 0 word = 0x010000; row 7 word = 0x800000.
  - `sr_latch` is high for 1 cycle; rows repeat every 58 cycles.
- Row 0 model with col0=01, col1=10, col7=11: word = 0x010102.
- Cursor, BLINK_BITS=4, cur_col=3, cur_player=10, row 7 empty:
  - Phase-1 frame → row 7 word 0x800008; phase-0 frame → 0x800000.
  - With (7,3)=01 → 0x800800 in both phases.
- game_over=1 with a populated board: phase-0 frames send 0x??0000 with the correct sel byte; phase-1 frames show the board with no cursor.
- Assert `rst` mid-SHIFT of row 4:
  - Outputs return to reset values the next cycle.
  - No `sr_latch` is emitted; scan restarts at row 0.
  - With CLK_DIV=1, `frame_done` pulses every 464 cycles after release.

Source files
------------

// File: rtl/connect_four_matrix_driver.sv
`default_nettype none
// ============================================================================
// Module   : connect_four_matrix_driver
// Purpose  : Scans the 8x8 Connect Four board and streams one 24-bit row word
//            {sel, red, green} into an external shift-register chain.
// Revision : 1.0 - initial release
// ============================================================================
module connect_four_matrix_driver #(
   parameter int CLK_DIV    = 4,
   parameter int BLINK_BITS = 22
) (
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] row_read,
   output logic [2:0] col_read,
   input  logic [1:0] data_in,
   input  logic [2:0] cur_col,
   input  logic [1:0] cur_player,
   input  logic       game_over,
   output logic       sr_data,
   output logic       sr_clk,
   output logic       sr_latch,
   output logic       frame_done
);

   localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
   localparam logic [4:0] c_bit_last = 5'd23;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_SHIFT = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   state_t                  r_state;
   logic [3:0]              r_fcnt;
   logic [2:0]              r_row;
   logic [2:0]              r_col;
   logic [6:0]              r_red;
   logic [6:0]              r_grn;
   logic [22:0]             r_shreg;
   logic [7:0]              r_div;
   logic [4:0]              r_bit;
   logic                    r_hi;
   logic                    r_sr_data;
   logic                    r_sr_clk;
   logic                    r_sr_latch;
   logic                    r_frame_done;
   logic [BLINK_BITS-1:0]   r_blink;
   logic                    r_phase_s;
   logic [2:0]              r_cc_s;
   logic [1:0]              r_cp_s;
   logic                    r_go_s;

   logic [7:0]              w_sel;
   logic [7:0]              w_red;
   logic [7:0]              w_grn;
   logic                    w_cur_free;
   logic [23:0]             w_word;
   logic [2:0]              w_cidx;

   assign w_cidx = r_fcnt[2:0] - 3'd1;

   // Cell 7 arrives on the last fetch cycle, so it is taken straight from data_in.
   always_comb begin
      w_sel      = 8'b1 << r_row;
      w_red      = {data_in == 2'b01, r_red};
      w_grn      = {data_in == 2'b10, r_grn};
      w_cur_free = !w_red[r_cc_s] && !w_grn[r_cc_s];
      if (r_row == 3'd7 && r_phase_s && !r_go_s && w_cur_free) begin
         if (r_cp_s == 2'b01) w_red[r_cc_s] = 1'b1;
         if (r_cp_s == 2'b10) w_grn[r_cc_s] = 1'b1;
      end
      if (r_go_s && !r_phase_s) begin
         w_red = '0;
         w_grn = '0;
      end
      w_word = {w_sel, w_red, w_grn};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_FETCH;
         r_fcnt       <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_red        <= '0;
         r_grn        <= '0;
         r_shreg      <= '0;
         r_div        <= '0;
         r_bit        <= '0;
         r_hi         <= 1'b0;
         r_sr_data    <= 1'b0;
         r_sr_clk     <= 1'b0;
         r_sr_latch   <= 1'b0;
         r_frame_done <= 1'b0;
         r_blink      <= '0;
         r_phase_s    <= 1'b0;
         r_cc_s       <= '0;
         r_cp_s       <= '0;
         r_go_s       <= 1'b0;
      end else begin
         r_blink      <= r_blink + 1'b1;
         r_frame_done <= 1'b0;
         case (r_state)
            S_FETCH: begin
               // Frame-wide display controls are frozen at the start of row 0.
               if (r_fcnt == 4'd0 && r_row == 3'd0) begin
                  r_phase_s <= r_blink[BLINK_BITS-1];
                  r_cc_s    <= cur_col;
                  r_cp_s    <= cur_player;
                  r_go_s    <= game_over;
               end
               if (r_fcnt != 4'd0 && r_fcnt != 4'd8) begin
                  r_red[w_cidx] <= (data_in == 2'b01);
                  r_grn[w_cidx] <= (data_in == 2'b10);
               end
               if (r_fcnt == 4'd8) begin
                  r_state   <= S_SHIFT;
                  r_shreg   <= w_word[22:0];
                  r_sr_data <= w_word[23];
                  r_div     <= '0;
                  r_bit     <= '0;
                  r_hi      <= 1'b0;
               end else begin
                  r_fcnt <= r_fcnt + 4'd1;
                  if (r_fcnt < 4'd7) r_col <= r_col + 3'd1;
               end
            end
            S_SHIFT: begin
               if (r_div == c_div_last) begin
                  r_div <= '0;
                  if (!r_hi) begin
                     r_hi     <= 1'b1;
                     r_sr_clk <= 1'b1;
                  end else begin
                     r_hi     <= 1'b0;
                     r_sr_clk <= 1'b0;
                     if (r_bit == c_bit_last) begin
                        r_state    <= S_LATCH;
                        r_sr_data  <= 1'b0;
                        r_sr_latch <= 1'b1;
                     end else begin
                        r_bit     <= r_bit + 5'd1;
                        r_sr_data <= r_shreg[22];
                        r_shreg   <= {r_shreg[21:0], 1'b0};
                     end
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            S_LATCH: begin
               if (r_div == c_div_last) begin
                  r_div        <= '0;
                  r_sr_latch   <= 1'b0;
                  r_state      <= S_FETCH;
                  r_fcnt       <= '0;
                  r_col        <= '0;
                  r_row        <= r_row + 3'd1;
                  r_frame_done <= (r_row == 3'd7);
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign row_read   = r_row;
   assign col_read   = r_col;
   assign sr_data    = r_sr_data;
   assign sr_clk     = r_sr_clk;
   assign sr_latch   = r_sr_latch;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_connect_four_matrix_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_connect_four_matrix_driver
// Purpose  : Two driver instances (CLK_DIV 1 and 4) against a cycle-level
//            timing model and a per-row word model of a random board.
// Revision : 1.0 - initial release
// ============================================================================
module tb_connect_four_matrix_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] cur_col = 3'd3;
   logic [1:0] cur_player = 2'b10;
   logic       game_over = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int D  = (g == 0) ? 1 : 4;
      localparam int BB = (g == 0) ? 5 : 4;
      localparam int P  = 9 + 49 * D;
      localparam int F  = 8 * P;

      logic [2:0]  row_read, col_read;
      logic [1:0]  data_in;
      logic        sr_data, sr_clk, sr_latch, frame_done;
      logic [1:0]  board [8][8];
      logic [1:0]  snap  [8][8];
      int          snap_phase = 0;
      logic [2:0]  snap_col = '0;
      logic [1:0]  snap_pl = '0;
      logic        snap_go = 1'b0;
      int          t = 0;
      bit          armed = 1'b0;
      logic [23:0] got_word = '0;
      logic        prev_clk = 1'b0, prev_latch = 1'b0;

      connect_four_matrix_driver #(.CLK_DIV(D), .BLINK_BITS(BB)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .row_read   (row_read),
         .col_read   (col_read),
         .data_in    (data_in),
         .cur_col    (cur_col),
         .cur_player (cur_player),
         .game_over  (game_over),
         .sr_data    (sr_data),
         .sr_clk     (sr_clk),
         .sr_latch   (sr_latch),
         .frame_done (frame_done)
      );

      initial begin
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
               board[r][c] = 2'b00;
               snap[r][c]  = 2'b00;
            end
         board[0][0] = 2'b01;
         board[0][1] = 2'b10;
         board[0][7] = 2'b11;
      end

      // Core read port: registered data, one cycle after the address.
      always @(posedge clk) data_in <= board[row_read][col_read];

      // t = index of the current cycle since the last reset edge.
      always @(posedge clk) begin
         if (rst) begin
            t     = 0;
            armed = 1'b1;
         end else begin
            if (t % F == 0) begin
               snap       = board;
               snap_phase = (t >> (BB - 1)) & 1;
               snap_col   = cur_col;
               snap_pl    = cur_player;
               snap_go    = game_over;
            end
            t = t + 1;
         end
      end

      always @(negedge clk) begin
         if (armed) begin
            int o, r, s;
            logic [7:0]  red, grn;
            logic [23:0] w;
            logic        e_data, e_clk, e_latch;
            o = t % P;
            r = (t / P) % 8;
            red = '0;
            grn = '0;
            for (int c = 0; c < 8; c++) begin
               red[c] = (snap[r][c] == 2'b01);
               grn[c] = (snap[r][c] == 2'b10);
            end
            if (r == 7 && snap_phase == 1 && !snap_go && !red[snap_col] && !grn[snap_col]) begin
               if (snap_pl == 2'b01) red[snap_col] = 1'b1;
               if (snap_pl == 2'b10) grn[snap_col] = 1'b1;
            end
            if (snap_go && snap_phase == 0) begin
               red = '0;
               grn = '0;
            end
            w = {8'(1 << r), red, grn};
            e_data = 1'b0; e_clk = 1'b0; e_latch = 1'b0;
            if (o >= 9 && o < 9 + 48 * D) begin
               s      = o - 9;
               e_data = w[23 - s / (2 * D)];
               e_clk  = (s % (2 * D)) >= D;
            end else if (o >= 9 + 48 * D) begin
               e_latch = 1'b1;
            end
            check_value("row_read",   32'(row_read),   32'(r));
            check_value("col_read",   32'(col_read),   32'((o < 8) ? o : 7));
            check_value("sr_data",    32'(sr_data),    32'(e_data));
            check_value("sr_clk",     32'(sr_clk),     32'(e_clk));
            check_value("sr_latch",   32'(sr_latch),   32'(e_latch));
            check_value("frame_done", 32'(frame_done), 32'(t > 0 && t % F == 0));

            if (t == 0) got_word = '0;
            if (sr_clk && !prev_clk) got_word = {got_word[22:0], sr_data};
            if (sr_latch && !prev_latch) begin
               check_value("word", 32'(got_word), 32'(w));
               got_word = '0;
            end
            prev_clk   = sr_clk;
            prev_latch = sr_latch;

            // New board only after row 7 has been fetched, so each frame sees one board.
            if (!rst && t % F == 7 * P + 20) begin
               for (int rr = 0; rr < 8; rr++)
                  for (int cc = 0; cc < 8; cc++)
                     board[rr][cc] = 2'($urandom_range(0, 3));
               if ($urandom_range(0, 1) == 1)
                  for (int cc = 0; cc < 8; cc++) board[7][cc] = 2'b00;
            end
         end
      end
   end

   initial begin
      repeat (1200) @(negedge clk);
      forever begin
         repeat (97) @(negedge clk);
         cur_col    = 3'($urandom_range(0, 7));
         cur_player = 2'($urandom_range(0, 3));
         game_over  = ($urandom_range(0, 3) == 0);
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // Abort instance 0 in the middle of row 4's shift, third frame.
      repeat (2 * 464 + 4 * 58 + 20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6 * 1640 + 50) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
